// File: rtl/y_frame_serializer_pkg.sv
// rtl/y_frame_serializer_pkg.sv - shared types, defaults and helpers for the y frame serializer
// Purpose: serializer FSM state encoding, default result width, and a
//          ceil-log2 helper used to size counters and FIFO pointers.
// Ports:   none (package).
package y_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam int W_DEFAULT = 40;

    // Smallest r with 2**r >= v; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/y_frame_serializer_if.sv
// rtl/y_frame_serializer_if.sv - result-word handshake between the core and the serializer
// Purpose: groups the parallel result word and its valid/ready handshake.
// Signals: y_in    - result word from the core
//          y_valid - y_in is valid this cycle
//          y_ready - serializer FIFO can accept a word
// Modports: master (core side), slave (serializer side).
interface y_frame_serializer_if
    import y_frame_pkg::*;
#(
    parameter int W = W_DEFAULT
) ();

    logic [W-1:0] y_in;
    logic         y_valid;
    logic         y_ready;

    modport master (
        output y_in,
        output y_valid,
        input  y_ready
    );

    modport slave (
        input  y_in,
        input  y_valid,
        output y_ready
    );

endinterface

// File: rtl/y_frame_serializer_fifo.sv
// rtl/y_frame_serializer_fifo.sv - small synchronous FIFO buffering result words
// Purpose: DEPTH-entry FIFO; head word is read straight from the storage registers.
// Ports:   clk, rst_n    - clock, asynchronous active-low reset
//          push, din     - write din when push and not full
//          pop           - advance head when pop and not empty
//          dout          - current head word
//          full, empty   - occupancy flags
module y_fifo
    import y_frame_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic          push_ok;
    logic          pop_ok;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_ok) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/y_frame_serializer.sv
// rtl/y_frame_serializer.sv - buffers 40-bit results and shifts them out as framed serial words
// Purpose: each buffered word goes out MSB-first on sout with sout_frame high,
//          followed by an even-parity bit, then GAP_CYCLES idle cycles.
// Ports:   clk, rst_n  - clock, asynchronous active-low reset
//          yin         - result word handshake (slave side: y_in, y_valid, y_ready)
//          clear       - synchronous clear of overflow and frame_cnt
//          sout        - serial data
//          sout_frame  - high while data or parity bits are on sout
//          busy        - FSM active or FIFO holds words
//          overflow    - sticky, a word was dropped on a full FIFO
//          frame_cnt   - completed frames, wraps modulo 2**CNT_W
module y_frame_serializer
    import y_frame_pkg::*;
#(
    parameter int W          = W_DEFAULT,
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    y_frame_serializer_if.slave  yin,
    input  logic                 clear,
    output logic                 sout,
    output logic                 sout_frame,
    output logic                 busy,
    output logic                 overflow,
    output logic [CNT_W-1:0]     frame_cnt
);

    localparam int BW = clog2(W);
    localparam int GW = clog2(GAP_CYCLES + 1);

    state_t           state_q, state_d;
    logic [W-1:0]     shreg_q, shreg_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic             par_q, par_d;
    logic             sout_q, sout_d;
    logic             frame_q, frame_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;

    logic             push;
    logic             pop;
    logic             load;
    logic             frame_done;
    logic [W-1:0]     head;
    logic             full;
    logic             empty;

    assign push = yin.y_valid && !full;

    y_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (yin.y_in),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bcnt_d     = bcnt_q;
        gcnt_d     = gcnt_q;
        par_d      = par_q;
        load       = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            IDLE: begin
                load = !empty;
            end
            SHIFT: begin
                shreg_d = shreg_q << 1;
                bcnt_d  = bcnt_q - 1'b1;
                if (bcnt_q == '0) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                frame_done = 1'b1;
                gcnt_d     = GW'(GAP_CYCLES - 1);
                state_d    = GAP;
            end
            GAP: begin
                if (gcnt_q == '0) begin
                    // Chain straight into the next frame when a word is waiting.
                    load = !empty;
                    if (empty) begin
                        state_d = IDLE;
                    end
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            shreg_d = head;
            bcnt_d  = BW'(W - 1);
            par_d   = ^head;
            state_d = SHIFT;
        end
        pop = load;

        // Serial outputs are precomputed from the next state so they leave flops.
        sout_d  = 1'b0;
        frame_d = 1'b0;
        if (state_d == SHIFT) begin
            sout_d  = shreg_d[W-1];
            frame_d = 1'b1;
        end else if (state_d == PARITY) begin
            sout_d  = par_d;
            frame_d = 1'b1;
        end

        // clear takes priority over a coincident overflow or frame completion.
        if (clear) begin
            ovf_d  = 1'b0;
            fcnt_d = '0;
        end else begin
            ovf_d  = ovf_q || (yin.y_valid && full);
            fcnt_d = frame_done ? fcnt_q + 1'b1 : fcnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
            par_q   <= 1'b0;
            sout_q  <= 1'b0;
            frame_q <= 1'b0;
            ovf_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            gcnt_q  <= gcnt_d;
            par_q   <= par_d;
            sout_q  <= sout_d;
            frame_q <= frame_d;
            ovf_q   <= ovf_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign yin.y_ready = !full;
    assign sout        = sout_q;
    assign sout_frame  = frame_q;
    assign busy        = (state_q != IDLE) || !empty;
    assign overflow    = ovf_q;
    assign frame_cnt   = fcnt_q;

endmodule
